muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the EX stage of the 5-stage pipeline.
- Produces a 2*WIDTH result split into lo/hi halves, matching the two-register writeback path: lo goes to write port 1, hi to write port 2.
- Multi-cycle operation with a start/busy/done handshake; the pipeline control stalls IF/ID/EX while busy is high.
- Supports signed/unsigned multiply and divide, flush, and divide-by-zero detection.

---
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide for the EX stage.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             dz_q, dz_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mc_q, mc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sh, dv, diff;
    logic [W2-1:0]    prod;
    logic             last;

    // Operand magnitudes and signs; only signed ops look at the sign bit.
    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Next-state, datapath step and result fix-up.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dz_d     = dz_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mq_d     = mq_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dbz_d    = dbz_q;
        sh       = '0;
        dv       = '0;
        diff     = '0;
        prod     = '0;
        last     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    div_d = op[1];
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    acc_d = '0;
                    if (op[1]) begin
                        mc_d     = {{WIDTH{1'b0}}, b_mag};
                        mq_d     = a_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                    end else begin
                        mc_d     = {{WIDTH{1'b0}}, a_mag};
                        mq_d     = b_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg ^ b_neg;
                    end
                    // Divide by zero skips iteration; raw dividend kept for hi.
                    if (op[1] && (b == '0)) begin
                        dz_d    = 1'b1;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (div_q) begin
                        sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
                        dv = {1'b0, mc_q[WIDTH-1:0]};
                        if (sh >= dv) begin
                            diff  = sh - dv;
                            acc_d = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, sh[WIDTH-1:0]};
                            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (mq_q[0]) begin
                            acc_d = acc_q + mc_q;
                        end
                        mc_d = mc_q << 1;
                        mq_d = mq_q >> 1;
                    end
                    last = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
                    if (!div_q && (mq_q[WIDTH-1:1] == '0)) begin
                        last = 1'b1;
                    end
`else
`endif
                    if (last) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (dz_q) begin
                        lo_d  = '1;
                        hi_d  = acc_q[WIDTH-1:0];
                        dbz_d = 1'b1;
                    end else if (div_q) begin
                        lo_d = neg_lo_q ? -mq_q : mq_q;
                        hi_d = neg_hi_q ? -acc_q[WIDTH-1:0]
                                        : acc_q[WIDTH-1:0];
                    end else begin
                        prod = neg_lo_q ? -acc_q : acc_q;
                        lo_d = prod[WIDTH-1:0];
                        hi_d = prod[W2-1:WIDTH];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            dz_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            mc_q     <= '0;
            mq_q     <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dz_q     <= dz_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mq_q     <= mq_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit (WIDTH=16).
// Expected results come from a behavioural model pushed to a scoreboard.
module tb_muldiv_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    typedef struct {
        string        tag;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Count every done pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, req);
        end
    endtask

    function automatic int mul_lat(input logic [1:0] o, input logic [W-1:0] y);
        logic [W-1:0] m;
        int           steps;
        m = (o[0] && y[W-1]) ? -y : y;
        steps = 1;
        for (int i = 0; i < W; i++) begin
            if (m[i]) steps = i + 1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        return steps + 1;
`else
        return (steps > 0) ? W + 1 : W + 1;
`endif
    endfunction

    function automatic exp_t model(input string tag, input logic [1:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t        e;
        logic [31:0] p;
        int          sx, sy, q, r;
        e.tag = tag;
        e.dbz = 1'b0;
        sx = o[0] ? int'($signed(x)) : int'(x);
        sy = o[0] ? int'($signed(y)) : int'(y);
        if (!o[1]) begin
            p = 32'(sx * sy);
            e.lo = p[W-1:0];
            e.hi = p[31:W];
            e.lat = mul_lat(o, y);
        end else if (y == '0) begin
            e.lo = '1;
            e.hi = x;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            e.lo = q[W-1:0];
            e.hi = r[W-1:0];
            e.lat = W + 1;
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   n;
        logic busy_ok;
        sb.push_back(model(tag, o, x, y));
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
        chk({tag, ".dbz_clr"}, 32'(div_by_zero), 32'd0);
        busy_ok = 1'b1;
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        e = sb.pop_front();
        chk({e.tag, ".lat"}, 32'(n), 32'(e.lat));
        chk({e.tag, ".busy_run"}, 32'(busy_ok), 32'd1);
        chk({e.tag, ".lo"}, 32'(result_lo), 32'(e.lo));
        chk({e.tag, ".hi"}, 32'(result_hi), 32'(e.hi));
        chk({e.tag, ".dbz"}, 32'(div_by_zero), 32'(e.dbz));
        chk({e.tag, ".busy_done"}, 32'(busy), 32'd0);
        last_lo = e.lo;
        last_hi = e.hi;
        tick();
        chk({e.tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   dc;
        int   n;
        exp_t e;
        rst = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.lo", 32'(result_lo), 32'd0);
        chk("rst.hi", 32'(result_hi), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b1;
        tick();

        // Directed vectors, with spec constants checked alongside the model.
        run_op("umul_ffff", 2'b00, 16'hFFFF, 16'hFFFF);
        chk("umul_ffff.const", {16'(result_hi), 16'(result_lo)}, 32'hFFFE0001);
        run_op("smul_m3x5", 2'b01, 16'hFFFD, 16'h0005);
        chk("smul_m3x5.const", {16'(result_hi), 16'(result_lo)}, 32'hFFFFFFF1);
        run_op("udiv_100_7", 2'b10, 16'd100, 16'd7);
        chk("udiv_100_7.const", {16'(result_hi), 16'(result_lo)}, 32'h0002000E);
        run_op("sdiv_m7_2", 2'b11, 16'hFFF9, 16'h0002);
        chk("sdiv_m7_2.const", {16'(result_hi), 16'(result_lo)}, 32'hFFFFFFFD);
        run_op("sdiv_ovf", 2'b11, 16'h8000, 16'hFFFF);
        chk("sdiv_ovf.const", {16'(result_hi), 16'(result_lo)}, 32'h00008000);
        run_op("div0", 2'b10, 16'h1234, 16'h0000);
        chk("div0.const", {16'(result_hi), 16'(result_lo)}, 32'h1234FFFF);
        run_op("sdiv0", 2'b11, 16'h8001, 16'h0000);
        run_op("smul_b0", 2'b01, 16'h7FFF, 16'h0000);
        run_op("umul_b1", 2'b00, 16'hBEEF, 16'h0001);
        run_op("smul_neg", 2'b01, 16'h8000, 16'h8000);
        run_op("sdiv_rneg", 2'b11, 16'h0007, 16'hFFFE);

        // Random mix of all four operations.
        for (int i = 0; i < 12; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        // Flush on edge 5: no done, results unchanged.
        dc = done_cnt;
        op = 2'b00;
        a = 16'h0003;
        b = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 25; i++) tick();
        chk("flush.no_done", 32'(done_cnt), 32'(dc));
        chk("flush.lo", 32'(result_lo), 32'(last_lo));
        chk("flush.hi", 32'(result_hi), 32'(last_hi));

        // Start and flush together in idle: nothing starts.
        dc = done_cnt;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("sf.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("sf.no_done", 32'(done_cnt), 32'(dc));

        // Start held high while busy: one operation, captured operands.
        dc = done_cnt;
        sb.push_back(model("hold", 2'b00, 16'd3, 16'd4));
        op = 2'b00;
        a = 16'd3;
        b = 16'd4;
        start = 1'b1;
        tick();
        a = 16'd9;
        b = 16'd9;
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        chk("hold.lat", 32'(n), 32'(e.lat));
        chk("hold.lo", 32'(result_lo), 32'(e.lo));
        chk("hold.hi", 32'(result_hi), 32'(e.hi));
        for (int i = 0; i < 25; i++) tick();
        chk("hold.one_done", 32'(done_cnt), 32'(dc + 1));
        chk("hold.idle", 32'(busy), 32'd0);

        // Result registers now hold 12; async reset on edge 8 of a new op.
        dc = done_cnt;
        op = 2'b11;
        a = 16'h7000;
        b = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.lo", 32'(result_lo), 32'd0);
        chk("arst.hi", 32'(result_hi), 32'd0);
        chk("arst.dbz", 32'(div_by_zero), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("arst.no_done", 32'(done_cnt), 32'(dc));

        // Normal operation resumes after reset.
        run_op("post_rst", 2'b10, 16'hFFFF, 16'h0010);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
